// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a byte stream and writes it into
// instruction memory, holding the CPU until a load completes with a good
// checksum.
//
// Frame on the link: SYNC_BYTE, length (0 means 256), data bytes, checksum
// (8-bit sum of the data bytes).
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_data   : incoming byte from the host link
//   in_valid  : in_data is valid this cycle
//   in_ready  : loader accepts in_data this cycle (low during a write cycle)
//   wr_en     : instruction-memory write strobe, one cycle per data byte
//   wr_addr   : instruction-memory write address
//   wr_data   : instruction-memory write data
//   cpu_hold  : holds the CPU while high
//   done      : last load completed with a good checksum
//   err       : last load failed (checksum mismatch or timeout)
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [8:0]  r_remain;
  logic [7:0]  r_addr;
  logic [7:0]  r_csum;
  logic [15:0] r_idle;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_err;

  logic w_accept;
  logic w_in_load;
  logic w_timeout;

  // Ready is gated by rst_n so it reads 0 throughout reset and 1 in the very
  // first cycle after release.
  assign in_ready  = rst_n & ~r_wr_en;
  assign w_accept  = in_valid & in_ready;
  assign w_in_load = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  // An accepted byte in the expiry cycle wins over the timeout.
  assign w_timeout = w_in_load && !w_accept && (r_idle == IDLE_LAST);

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_remain   <= '0;
      r_addr     <= '0;
      r_csum     <= '0;
      r_idle     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;

      if (!w_in_load || w_accept || w_timeout) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 16'd1;
      end

      // Write cycle: wr_addr shows the current address while the counters
      // advance at the end of the cycle, so a 256-byte load leaves the
      // address wrapped to 0 without issuing another write.
      if (r_wr_en) begin
        r_addr   <= r_addr + 8'd1;
        r_csum   <= r_csum + r_wr_data;
        r_remain <= r_remain - 9'd1;
        if (r_remain == 9'd1) begin
          r_state <= CSUM;
        end
      end

      case (r_state)
        IDLE, DONE, ERR: begin
          if (w_accept && (in_data == SYNC_BYTE)) begin
            r_state    <= LEN;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        LEN: begin
          if (w_accept) begin
            r_remain <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            r_addr   <= '0;
            r_csum   <= '0;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= in_data;
          end
        end
        CSUM: begin
          if (w_accept) begin
            if (in_data == r_csum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_timeout) begin
        r_state <= ERR;
        r_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives framed loads over the byte link and checks
// the memory writes and load outcome against a transaction-level model.
module tb_prog_loader;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned TMO  = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_hold;
  logic       done;
  logic       err;

  prog_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_res;
    logic [7:0] a;
    logic [7:0] d;
    bit         ok;
  } exp_t;

  exp_t       q[$];
  logic [7:0] pl[$];
  int         checks   = 0;
  int         failures = 0;
  bit         gaps     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_res = 1'b0; e.a = a; e.d = d; e.ok = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_result(input bit ok);
    exp_t e;
    e.is_res = 1'b1; e.a = '0; e.d = '0; e.ok = ok;
    q.push_back(e);
  endtask

  // Called just after a falling edge; returns at the falling edge following
  // the rising edge on which the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_wait actual=0 required=1");
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] noise_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SYNC);
    return b;
  endfunction

  // Sends a full frame carrying pl[] and the given checksum byte; the model
  // expects one write per byte at addresses 0.. and a verdict from the sum.
  task automatic load_bytes(input logic [7:0] csum_byte);
    int n;
    int s;
    n = pl.size();
    s = 0;
    send_byte(SYNC);
    chk("sync_clears_done", done, 0);
    chk("sync_clears_err", err, 0);
    chk("sync_holds_cpu", cpu_hold, 1);
    send_byte((n == 256) ? 8'd0 : 8'(n));
    for (int i = 0; i < n; i++) begin
      push_write(8'(i), pl[i]);
      s += int'(pl[i]);
      send_byte(pl[i]);
    end
    push_result(csum_byte == 8'(s % 256));
    send_byte(csum_byte);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // Monitor: pops an expectation on every write strobe and every rising
  // done/err, independently of the stimulus process.
  bit pd, pe;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pd = 1'b0;
      pe = 1'b0;
    end else begin
      if (wr_en) begin
        chk("ready_low_in_write", in_ready, 0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=(%0h,%0h) required=none", wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          chk("write_kind", e.is_res, 0);
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      if ((done && !pd) || (err && !pe)) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=done%0d/err%0d required=none", done, err);
        end else begin
          e = q.pop_front();
          chk("result_kind", e.is_res, 1);
          chk("done", done, e.ok);
          chk("err", err, !e.ok);
          chk("cpu_hold", cpu_hold, !e.ok);
        end
      end
      if (done || err) chk("done_err_exclusive", done & err, 0);
      pd = done;
      pe = err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cpu_hold", cpu_hold, 1);
    @(negedge clk);

    // Good three-byte load.
    pl = '{8'h11, 8'h22, 8'h33};
    load_bytes(8'h66);

    // Bad checksum, then a fresh load clears err.
    pl = '{8'h10, 8'h20};
    load_bytes(8'h31);
    pl = '{8'h5A};
    load_bytes(8'h5A);

    // Full 256-byte load, address wraps with no extra write.
    pl = {};
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    load_bytes(8'h80);
    chk("addr_wrap", wr_addr, 0);

    // Noise before sync is dropped; sync value inside a load is data.
    send_byte(8'h00);
    send_byte(8'h7F);
    pl = '{SYNC};
    load_bytes(SYNC);

    // Timeout after two of four data bytes.
    send_byte(SYNC);
    send_byte(8'h04);
    push_write(8'd0, 8'h01);
    send_byte(8'h01);
    push_write(8'd1, 8'h02);
    send_byte(8'h02);
    push_result(1'b0);
    in_valid = 1'b0;
    cnt = 0;
    while (!err && cnt < int'(TMO) + 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_hold", cpu_hold, 1);

    // Reset during the write cycle of the second data byte of a 4-byte load.
    send_byte(SYNC);
    send_byte(8'h04);
    push_write(8'd0, 8'hC3);
    send_byte(8'hC3);
    push_write(8'd1, 8'h3C);
    send_byte(8'h3C);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rerst_in_ready", in_ready, 1);
    chk("rerst_cpu_hold", cpu_hold, 1);
    @(negedge clk);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_bytes(8'h0A);

    // Randomized loads with idle gaps and leading noise.
    gaps = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int n;
      int s;
      n  = $urandom_range(1, 16);
      pl = {};
      s  = 0;
      repeat ($urandom_range(0, 2)) send_byte(noise_byte());
      for (int i = 0; i < n; i++) begin
        pl.push_back(8'($urandom));
        s += int'(pl[i]);
      end
      if ($urandom_range(0, 2) == 0)
        load_bytes(8'(s + 1 + int'($urandom_range(0, 254))));
      else
        load_bytes(8'(s));
    end
    gaps = 1'b0;

    cnt = 0;
    while (q.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
